// File: rtl/therm_to_onehot_pipe.sv
// Two-stage valid/ready thermometer-to-one-hot converter with binary index.
// Optional saturating counters built when THERM_TO_ONEHOT_STATS_EN is defined.
module therm_to_onehot_pipe #(
  parameter int N   = 8,
  parameter int DIR = 0,
  parameter int IW  = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_therm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_onehot,
  output logic [IW-1:0] out_idx,
  output logic          out_zero,
  output logic          out_err,
  output logic [15:0]   stat_words,
  output logic [15:0]   stat_errs
);

  typedef struct packed {
    logic [N-1:0] word;
    logic [N-1:0] edge_oh;
  } s1_t;

  typedef struct packed {
    logic [N-1:0]  onehot;
    logic [IW-1:0] idx;
    logic          zero;
    logic          err;
  } s2_t;

  logic         s1_valid;
  s1_t          s1;
  s2_t          s2;
  logic         s1_adv;
  logic         s2_adv;
  logic [N-1:0] edge_c;
  logic [N-1:0] canon_c;
  logic [IW-1:0] idx_c;
  logic         run_c;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Last hit wins, so the scan order picks the outermost set bit.
  always_comb begin
    edge_c = '0;
    if (DIR == 0) begin
      for (int i = 0; i < N; i++) begin
        if (in_therm[i]) begin
          edge_c    = '0;
          edge_c[i] = 1'b1;
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (in_therm[i]) begin
          edge_c    = '0;
          edge_c[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    canon_c = '0;
    run_c   = 1'b0;
    if (DIR == 0) begin
      for (int i = N - 1; i >= 0; i--) begin
        run_c      = run_c | s1.edge_oh[i];
        canon_c[i] = run_c;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        run_c      = run_c | s1.edge_oh[i];
        canon_c[i] = run_c;
      end
    end
  end

  always_comb begin
    idx_c = '0;
    for (int i = 0; i < N; i++) begin
      if (s1.edge_oh[i]) idx_c = IW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1        <= '0;
      out_valid <= 1'b0;
      s2        <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1.word    <= in_therm;
          s1.edge_oh <= edge_c;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          s2.onehot <= s1.edge_oh;
          s2.idx    <= idx_c;
          s2.zero   <= (s1.word == '0);
          s2.err    <= (s1.word != canon_c);
        end
      end
    end
  end

  assign out_onehot = s2.onehot;
  assign out_idx    = s2.idx;
  assign out_zero   = s2.zero;
  assign out_err    = s2.err;

`ifdef THERM_TO_ONEHOT_STATS_EN
  logic [15:0] words_q;
  logic [15:0] errs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      words_q <= '0;
      errs_q  <= '0;
    end else begin
      if (in_valid && in_ready && (words_q != 16'hFFFF))
        words_q <= words_q + 16'd1;
      if (out_valid && out_ready && out_err && (errs_q != 16'hFFFF))
        errs_q <= errs_q + 16'd1;
    end
  end

  assign stat_words = words_q;
  assign stat_errs  = errs_q;
`else
  assign stat_words = '0;
  assign stat_errs  = '0;
`endif

endmodule

// File: tb/tb_therm_to_onehot_pipe.sv
// Directed bench: DIR=0 and DIR=1 instances side by side.
// Stat checks follow THERM_TO_ONEHOT_STATS_EN.
module tb_therm_to_onehot_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       v0, r0, ov0, ordy0, z0, e0;
  logic       v1, r1, ov1, ordy1, z1, e1;
  logic [7:0] w0, w1, oh0, oh1;
  logic [2:0] ix0, ix1;
  logic [15:0] sw0, se0, sw1, se1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  therm_to_onehot_pipe #(.N(8), .DIR(0)) u0 (
    .clk(clk), .rst(rst),
    .in_valid(v0), .in_ready(r0), .in_therm(w0),
    .out_valid(ov0), .out_ready(ordy0),
    .out_onehot(oh0), .out_idx(ix0),
    .out_zero(z0), .out_err(e0),
    .stat_words(sw0), .stat_errs(se0)
  );

  therm_to_onehot_pipe #(.N(8), .DIR(1)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(v1), .in_ready(r1), .in_therm(w1),
    .out_valid(ov1), .out_ready(ordy1),
    .out_onehot(oh1), .out_idx(ix1),
    .out_zero(z1), .out_err(e1),
    .stat_words(sw1), .stat_errs(se1)
  );

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    #2000000;
    $error("FAIL timeout: simulation did not finish");
    $finish;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pair(
    input logic [7:0] a, input logic [7:0] a_oh, input logic [2:0] a_ix,
    input logic a_z, input logic a_e,
    input logic [7:0] b, input logic [7:0] b_oh, input logic [2:0] b_ix,
    input logic b_z, input logic b_e
  );
    v0 = 1'b1; w0 = a;
    v1 = 1'b1; w1 = b;
    tick();
    v0 = 1'b0; v1 = 1'b0;
    chk("d0_not_yet_valid", ov0, 1'b0);
    tick();
    chk("d0_valid", ov0, 1'b1);
    chk("d0_onehot", oh0, a_oh);
    chk("d0_idx", ix0, a_ix);
    chk("d0_zero", z0, a_z);
    chk("d0_err", e0, a_e);
    chk("d1_valid", ov1, 1'b1);
    chk("d1_onehot", oh1, b_oh);
    chk("d1_idx", ix1, b_ix);
    chk("d1_zero", z1, b_z);
    chk("d1_err", e1, b_e);
    tick();
    chk("d0_drained", ov0, 1'b0);
    chk("d1_drained", ov1, 1'b0);
  endtask

  logic [9:0] exp_ir = 10'b1111100011;
  logic [9:0] exp_ov = 10'b0111111100;
  logic [7:0] hold_oh;
  logic [2:0] hold_ix;
  int         next_idx;
  int         sent;
  logic [7:0] stream [4];

  initial begin
    rst = 1'b1;
    v0 = 1'b0; w0 = '0; ordy0 = 1'b1;
    v1 = 1'b0; w1 = '0; ordy1 = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_out_valid", ov0, 1'b0);
    chk("rst_onehot", oh0, 8'h00);
    chk("rst_idx", ix0, 3'd0);
    chk("rst_zero", z0, 1'b0);
    chk("rst_err", e0, 1'b0);
    chk("rst_in_ready", r0, 1'b1);
    chk("rst_stat_words", sw0, 16'h0000);
    chk("rst_stat_errs", se0, 16'h0000);

    pair(8'h0F, 8'h08, 3'd3, 1'b0, 1'b0,
         8'hF8, 8'h08, 3'd3, 1'b0, 1'b0);
    pair(8'h2F, 8'h20, 3'd5, 1'b0, 1'b1,
         8'h00, 8'h00, 3'd0, 1'b1, 1'b0);
`ifdef THERM_TO_ONEHOT_STATS_EN
    chk("stat_errs_bubble", se0, 16'd1);
    chk("stat_words_two", sw0, 16'd2);
    chk("stat_errs_dir1_none", se1, 16'd0);
`else
    chk("stat_errs_off", se0, 16'd0);
    chk("stat_words_off", sw0, 16'd0);
`endif
    pair(8'hFF, 8'h80, 3'd7, 1'b0, 1'b0,
         8'hFF, 8'h01, 3'd0, 1'b0, 1'b0);
    pair(8'h00, 8'h00, 3'd0, 1'b1, 1'b0,
         8'hD8, 8'h08, 3'd3, 1'b0, 1'b1);

    stream[0] = 8'h01; stream[1] = 8'h03;
    stream[2] = 8'h07; stream[3] = 8'h0F;
    sent = 0;
    next_idx = 0;
    hold_oh = '0;
    hold_ix = '0;
    for (int c = 1; c <= 10; c++) begin
      v0    = (sent < 4);
      w0    = (sent < 4) ? stream[sent] : 8'h00;
      ordy0 = !(c >= 3 && c <= 5);
      #1;
      if (v0) chk("stream_in_ready", r0, exp_ir[c-1]);
      chk("stream_out_valid", ov0, exp_ov[c-1]);
      if (c == 4 || c == 5) begin
        chk("stall_onehot", oh0, hold_oh);
        chk("stall_idx", ix0, hold_ix);
      end
      hold_oh = oh0;
      hold_ix = ix0;
      if (ov0 && ordy0) begin
        chk("stream_order_idx", ix0, 3'(next_idx));
        next_idx++;
      end
      if (v0 && r0) sent++;
      tick();
    end
    v0 = 1'b0;
    ordy0 = 1'b1;
    chk("stream_out_count", next_idx, 4);

    ordy0 = 1'b0;
    v0 = 1'b1; w0 = 8'h07;
    tick();
    w0 = 8'h3F;
    tick();
    v0 = 1'b0;
    chk("full_in_ready", r0, 1'b0);
    chk("full_out_valid", ov0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ordy0 = 1'b1;
    chk("post_rst_out_valid", ov0, 1'b0);
    chk("post_rst_in_ready", r0, 1'b1);
    chk("post_rst_stat_words", sw0, 16'd0);
    chk("post_rst_stat_errs", se0, 16'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("no_stale_word", ov0, 1'b0);
    end

`ifdef THERM_TO_ONEHOT_STATS_EN
    v0 = 1'b1; w0 = 8'h0B;
    for (int k = 0; k < 70000; k++) tick();
    v0 = 1'b0;
    chk("stat_words_sat", sw0, 16'hFFFF);
    chk("stat_errs_sat", se0, 16'hFFFF);
`else
    v0 = 1'b1; w0 = 8'h0B;
    for (int k = 0; k < 20; k++) tick();
    v0 = 1'b0;
    chk("stat_words_tied", sw0, 16'd0);
    chk("stat_errs_tied", se0, 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/therm_to_onehot_pipe.md
Name: therm_to_onehot_pipe

Overview:
- Pipelined, flow-controlled converter from thermometer code to one-hot code plus binary position index. It is the inverse of the team's one-hot-to-thermometer encoder, e.g. 00001111 -> 00001000.
- Sits on the canonical-form datapath where thermometer-coded SC values are read back into positional or binary form.
- Two register stages with valid/ready handshake on both sides; malformed (bubbled) thermometer words are flagged rather than silently decoded.

Parameters:
- N, 8: code width; power of two, N >= 2.
- DIR, 0: 0 = thermometer fills from LSB (00001111 marks bit 3); 1 = fills from MSB (11111000 marks bit 3).
- IW, $clog2(N): index width (derived; not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  converter can accept input this cycle
- in_therm  in  N  thermometer code
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts output
- out_onehot  out  N  one-hot edge position
- out_idx  out  IW  binary index of the set one-hot bit
- out_zero  out  1  input had no set bits
- out_err  out  1  input was not a legal thermometer code
- stat_words  out  16  accepted-word count (see Optional Feature)
- stat_errs  out  16  error-word count (see Optional Feature)

Behaviour:
- Reset (rst=1 at posedge): both stage valids cleared; out_valid=0, out_onehot=0, out_idx=0, out_zero=0, out_err=0, stat_* = 0. in_ready is 1 in the first cycle after reset.
- Transfers:
  - Input transfer on in_valid & in_ready.
  - Output transfer on out_valid & out_ready.
  - out_* payload holds stable while out_valid & !out_ready.
- Stage 1 (S1): on input transfer, register in_therm and compute the edge.
  - DIR=0: edge = highest set bit of in_therm.
  - DIR=1: edge = lowest set bit of in_therm.
  - Register the edge as one-hot.
- Stage 2 (S2): from S1 contents, register:
  - out_onehot = edge.
  - out_idx = binary position of edge.
  - out_zero = (word == 0).
  - out_err = (word != canonical thermometer of edge). Canonical for DIR=0 = all bits at or below edge set; for DIR=1 = all bits at or above edge set.
- Zero word: out_onehot=0, out_idx=0, out_zero=1, out_err=0.
- Bubbled word: onehot/idx still reflect the edge rule; out_err=1.
- All-ones word:
  - DIR=0: idx=N-1.
  - DIR=1: idx=0.
- Latency: 2 cycles from input transfer to out_valid with an unstalled pipe. Throughput: 1 word/cycle.
- Flow control:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv.
  - in_ready depends on out_ready combinationally; no combinational path from in_valid to in_ready.
- Simultaneous output and input transfer on a full pipe: both occur; no bubble is inserted and no word is lost or duplicated.
- Reset mid-operation: in-flight words are discarded and no output transfer occurs in the reset cycle.
- Ordering is strictly FIFO.

Optional Feature:
- Macro: THERM_TO_ONEHOT_STATS_EN.
- Defined:
  - stat_words increments on each input transfer.
  - stat_errs increments on each output transfer with out_err=1.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: stat_words and stat_errs are tied to 0 and no counter logic is built. Ports are always present.

Test Plan:
- N=8, DIR=0, out_ready=1, in_therm=8'b00001111 -> 2 cycles later out_onehot=8'b00001000, out_idx=3, out_zero=0, out_err=0.
- N=8, DIR=1, in_therm=8'b11111000 -> out_onehot=8'b00001000, out_idx=3. Then 8'h00 -> out_zero=1, out_idx=0. Then 8'hFF -> out_idx=0, out_err=0.
- DIR=0, in_therm=8'b00101111 (bubble) -> out_onehot=8'b00100000, out_idx=5, out_err=1. With macro defined, stat_errs=1.
- Back-to-back stream 8'h01, 8'h03, 8'h07, 8'h0F with out_ready low for cycles 3-5:
  - in_ready drops after both stages fill.
  - Outputs idx 0, 1, 2, 3 arrive in order with no loss or duplication.
  - Payload stays stable while stalled.
- Pipe full, assert rst for 1 cycle -> out_valid=0 next cycle, no stale words emerge, stat counters = 0.
- Macro defined, 70000 accepted words -> stat_words saturates at 16'hFFFF.
